// File: rtl/sot_alignment_monitor_if.sv
// ----------------------------------------------------------------------------
// sot_alignment_monitor_if
// Purpose : groups the frame-aligner side and status signals of the SOT
//           alignment monitor into one bundle.
// Signals : enable, sot_is_aligned, sot_unstable, timeout_i, cnt_reset,
//           sbits_i          -> driven toward the monitor
//           sbits_o, realign_req, state_o, locked_o, fail_o, retry_cnt_o,
//           unstable_cnt_o   -> driven by the monitor
// Modports: slave  = monitor view, master = driver/consumer view.
// ----------------------------------------------------------------------------
interface sot_alignment_monitor_if #(
   parameter int MXSBITS = 64
);
   logic               enable;
   logic               sot_is_aligned;
   logic               sot_unstable;
   logic [15:0]        timeout_i;
   logic               cnt_reset;
   logic [MXSBITS-1:0] sbits_i;
   logic [MXSBITS-1:0] sbits_o;
   logic               realign_req;
   logic [2:0]         state_o;
   logic               locked_o;
   logic               fail_o;
   logic [3:0]         retry_cnt_o;
   logic [7:0]         unstable_cnt_o;

   modport slave (
      input  enable, sot_is_aligned, sot_unstable, timeout_i, cnt_reset, sbits_i,
      output sbits_o, realign_req, state_o, locked_o, fail_o, retry_cnt_o,
             unstable_cnt_o
   );

   modport master (
      output enable, sot_is_aligned, sot_unstable, timeout_i, cnt_reset, sbits_i,
      input  sbits_o, realign_req, state_o, locked_o, fail_o, retry_cnt_o,
             unstable_cnt_o
   );
endinterface

// File: rtl/sot_alignment_monitor.sv
// ----------------------------------------------------------------------------
// sot_alignment_monitor
// Purpose : supervises a frame aligner. Pulses realign_req, waits for lock
//           with a timeout, retries up to MAX_RETRIES times, forwards S-bits
//           only while locked and counts lock losses.
// Ports   : clock - single rising-edge clock
//           reset - asynchronous active-high reset
//           bus   - sot_alignment_monitor_if.slave (control inputs, S-bits,
//                   realign_req, state/status/counter outputs)
// ----------------------------------------------------------------------------
module sot_alignment_monitor #(
   parameter int RESET_CYCLES = 4,
   parameter int MAX_RETRIES  = 4,
   parameter int MXSBITS      = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   sot_alignment_monitor_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_REALIGN   = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_LOCKED    = 3'd3,
      ST_FAILED    = 3'd4
   } state_t;

   localparam logic [3:0] LP_RESET_CYCLES = 4'(RESET_CYCLES);
   localparam logic [3:0] LP_MAX_RETRIES  = 4'(MAX_RETRIES);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t               r_state;
   logic [3:0]           r_pulse;
   logic [15:0]          r_timer;
   logic [3:0]           r_retry;
   logic [7:0]           r_unstable_cnt;
   logic                 r_realign;
   logic                 r_locked;
   logic                 r_fail;
   logic [MXSBITS-1:0]   r_sbits_p1;

   state_t               w_next;
   logic [3:0]           w_pulse_next;
   logic [15:0]          w_timer_next;
   logic [3:0]           w_retry_next;
   logic [3:0]           w_retry_inc;
   logic                 w_unstable_inc;
   logic                 w_lock_ok;

   assign w_lock_ok   = bus.sot_is_aligned && !bus.sot_unstable;
   assign w_retry_inc = r_retry + 4'd1;

   always_comb begin
      w_next         = r_state;
      w_pulse_next   = r_pulse;
      w_timer_next   = r_timer;
      w_retry_next   = r_retry;
      w_unstable_inc = 1'b0;
      if (!bus.enable) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_next       = ST_REALIGN;
               w_pulse_next = LP_RESET_CYCLES;
               w_retry_next = 4'd0;
            end
            ST_REALIGN: begin
               // Counter holds the cycles still to go, including this one.
               if (r_pulse <= 4'd1) begin
                  w_next       = ST_WAIT_LOCK;
                  w_pulse_next = 4'd0;
                  w_timer_next = 16'd0;
               end else begin
                  w_pulse_next = r_pulse - 4'd1;
               end
            end
            ST_WAIT_LOCK: begin
               // Lock is tested first so a lock on the timeout cycle wins.
               if (w_lock_ok) begin
                  w_next       = ST_LOCKED;
                  w_retry_next = 4'd0;
               end else if (r_timer == bus.timeout_i) begin
                  w_retry_next = w_retry_inc;
                  if (w_retry_inc == LP_MAX_RETRIES) begin
                     w_next = ST_FAILED;
                  end else begin
                     w_next       = ST_REALIGN;
                     w_pulse_next = LP_RESET_CYCLES;
                  end
               end else begin
                  w_timer_next = r_timer + 16'd1;
               end
            end
            ST_LOCKED: begin
               if (!w_lock_ok) begin
                  w_unstable_inc = 1'b1;
                  w_next         = ST_REALIGN;
                  w_pulse_next   = LP_RESET_CYCLES;
               end
            end
            ST_FAILED: begin
               w_next = ST_FAILED;
            end
            default: begin
               w_next = ST_IDLE;
            end
         endcase
      end
   end

   // Stage p1: state, counters, registered decodes of the next state and
   // the lock-gated S-bit register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_pulse        <= 4'd0;
         r_timer        <= 16'd0;
         r_retry        <= 4'd0;
         r_unstable_cnt <= 8'd0;
         r_realign      <= 1'b0;
         r_locked       <= 1'b0;
         r_fail         <= 1'b0;
         r_sbits_p1     <= '0;
      end else begin
         r_state   <= w_next;
         r_pulse   <= w_pulse_next;
         r_timer   <= w_timer_next;
         r_retry   <= w_retry_next;
         r_realign <= (w_next == ST_REALIGN);
         r_locked  <= (w_next == ST_LOCKED);
         r_fail    <= (w_next == ST_FAILED);
         // A clear wins over a simultaneous increment.
         if (bus.cnt_reset) begin
            r_unstable_cnt <= 8'd0;
         end else if (w_unstable_inc) begin
            r_unstable_cnt <= sat_inc8(r_unstable_cnt);
         end
         r_sbits_p1 <= (r_state == ST_LOCKED) ? bus.sbits_i : '0;
      end
   end

   assign bus.state_o        = r_state;
   assign bus.realign_req    = r_realign;
   assign bus.locked_o       = r_locked;
   assign bus.fail_o         = r_fail;
   assign bus.retry_cnt_o    = r_retry;
   assign bus.unstable_cnt_o = r_unstable_cnt;
   assign bus.sbits_o        = r_sbits_p1;

endmodule

// File: tb/tb_sot_alignment_monitor.sv
// ----------------------------------------------------------------------------
// tb_sot_alignment_monitor
// Purpose : directed self-checking bench for sot_alignment_monitor.
// ----------------------------------------------------------------------------
module tb_sot_alignment_monitor;

   localparam logic [2:0] S_IDLE = 3'd0, S_REALIGN = 3'd1, S_WAIT = 3'd2,
                          S_LOCKED = 3'd3, S_FAILED = 3'd4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sot_alignment_monitor_if #(.MXSBITS(64)) bus ();

   sot_alignment_monitor #(
      .RESET_CYCLES(4),
      .MAX_RETRIES (4),
      .MXSBITS     (64)
   ) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic chk(input logic [63:0] obs);
      exp_t e;
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step_chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      push(tag, expv);
      chk(obs);
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
      int n = 0;
      while (bus.state_o !== st && n < budget) begin
         tick();
         n++;
      end
      if (bus.state_o !== st) begin
         n_assert++;
         n_fail++;
         $display("FAIL %s: timed out, state_o=%0d expected %0d", tag, bus.state_o, st);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] v;
      int          n_hi;
      int          pulses;
      int          r2;
      logic        prev;

      bus.enable         = 1'b0;
      bus.sot_is_aligned = 1'b0;
      bus.sot_unstable   = 1'b0;
      bus.timeout_i      = 16'd100;
      bus.cnt_reset      = 1'b0;
      bus.sbits_i        = '0;

      // Reset state
      #12;
      step_chk("rst_state",   bus.state_o,        S_IDLE);
      step_chk("rst_realign", bus.realign_req,    0);
      step_chk("rst_locked",  bus.locked_o,       0);
      step_chk("rst_fail",    bus.fail_o,         0);
      step_chk("rst_retry",   bus.retry_cnt_o,    0);
      step_chk("rst_unst",    bus.unstable_cnt_o, 0);
      step_chk("rst_sbits",   bus.sbits_o,        0);
      rst = 1'b0;
      tick();
      step_chk("idle_no_enable", bus.state_o, S_IDLE);

      // Basic lock
      bus.enable = 1'b1;
      tick();
      step_chk("basic_realign_state", bus.state_o, S_REALIGN);
      n_hi = 0;
      while (bus.realign_req && n_hi < 20) begin
         n_hi++;
         tick();
      end
      step_chk("basic_pulse_len", n_hi, 4);
      step_chk("basic_wait_state", bus.state_o, S_WAIT);
      repeat (9) tick();
      step_chk("basic_not_locked_yet", bus.locked_o, 0);
      bus.sot_is_aligned = 1'b1;
      tick();
      step_chk("basic_locked_state", bus.state_o, S_LOCKED);
      step_chk("basic_locked_o", bus.locked_o, 1);
      step_chk("basic_retry", bus.retry_cnt_o, 0);
      step_chk("basic_sbits_first", bus.sbits_o, 0);
      for (int i = 0; i < 4; i++) begin
         v = {$urandom, $urandom};
         bus.sbits_i = v;
         push("sbits_locked", v);
         tick();
         chk(bus.sbits_o);
      end

      // Lock loss
      v = {$urandom, $urandom};
      bus.sbits_i = v;
      bus.sot_unstable = 1'b1;
      push("loss_sbits_last", v);
      tick();
      chk(bus.sbits_o);
      step_chk("loss_state", bus.state_o, S_REALIGN);
      step_chk("loss_unst", bus.unstable_cnt_o, 1);
      step_chk("loss_locked_o", bus.locked_o, 0);
      step_chk("loss_realign", bus.realign_req, 1);
      bus.sot_unstable = 1'b0;
      bus.sbits_i = {$urandom, $urandom};
      push("loss_sbits_zero", 0);
      tick();
      chk(bus.sbits_o);
      wait_state(S_LOCKED, 20, "relock");
      step_chk("relock_locked_o", bus.locked_o, 1);
      step_chk("relock_unst", bus.unstable_cnt_o, 1);

      // Saturation and clear
      for (int i = 0; i < 300; i++) begin
         wait_state(S_LOCKED, 20, "sat_relock");
         bus.sot_unstable = 1'b1;
         tick();
         bus.sot_unstable = 1'b0;
      end
      step_chk("sat_unst", bus.unstable_cnt_o, 255);
      wait_state(S_LOCKED, 20, "sat_relock_final");
      step_chk("sat_hold", bus.unstable_cnt_o, 255);
      bus.sot_unstable = 1'b1;
      bus.cnt_reset    = 1'b1;
      tick();
      bus.sot_unstable = 1'b0;
      bus.cnt_reset    = 1'b0;
      step_chk("clear_vs_inc", bus.unstable_cnt_o, 0);
      step_chk("clear_state", bus.state_o, S_REALIGN);

      // Enable drop mid-REALIGN, then lock/timeout tie
      bus.enable = 1'b0;
      tick();
      step_chk("dis_state", bus.state_o, S_IDLE);
      step_chk("dis_realign", bus.realign_req, 0);
      bus.sot_is_aligned = 1'b0;
      bus.timeout_i = 16'd20;
      bus.enable = 1'b1;
      tick();
      n_hi = 0;
      while (bus.realign_req && n_hi < 20) begin
         n_hi++;
         tick();
      end
      step_chk("tie_wait_state", bus.state_o, S_WAIT);
      repeat (20) tick();
      step_chk("tie_still_waiting", bus.state_o, S_WAIT);
      bus.sot_is_aligned = 1'b1;
      tick();
      step_chk("tie_state", bus.state_o, S_LOCKED);
      step_chk("tie_retry", bus.retry_cnt_o, 0);

      // Retry to failure
      bus.enable = 1'b0;
      bus.sot_is_aligned = 1'b0;
      tick();
      step_chk("fail_pre_idle", bus.state_o, S_IDLE);
      bus.enable = 1'b1;
      pulses = 0;
      r2 = -1;
      prev = 1'b0;
      for (int n = 0; n < 1000 && bus.state_o !== S_FAILED; n++) begin
         tick();
         if (bus.realign_req && !prev) begin
            pulses++;
            if (pulses == 2) r2 = int'(bus.retry_cnt_o);
         end
         prev = bus.realign_req;
      end
      step_chk("fail_state", bus.state_o, S_FAILED);
      step_chk("fail_pulses", pulses, 4);
      step_chk("fail_retry_after_first", r2, 1);
      step_chk("fail_retry", bus.retry_cnt_o, 4);
      step_chk("fail_o", bus.fail_o, 1);
      step_chk("fail_locked_o", bus.locked_o, 0);
      bus.sbits_i = {$urandom, $urandom};
      push("fail_sbits", 0);
      tick();
      chk(bus.sbits_o);
      step_chk("fail_hold", bus.state_o, S_FAILED);
      bus.enable = 1'b0;
      tick();
      step_chk("fail_exit_state", bus.state_o, S_IDLE);
      step_chk("fail_exit_fail_o", bus.fail_o, 0);

      // Async reset mid-REALIGN with a nonzero retry count
      bus.timeout_i = 16'd0;
      bus.enable = 1'b1;
      repeat (6) tick();
      step_chk("ar_pre_state", bus.state_o, S_REALIGN);
      step_chk("ar_pre_retry", bus.retry_cnt_o, 1);
      step_chk("ar_pre_realign", bus.realign_req, 1);
      #2;
      rst = 1'b1;
      #1;
      step_chk("ar_realign", bus.realign_req, 0);
      step_chk("ar_state", bus.state_o, S_IDLE);
      step_chk("ar_retry", bus.retry_cnt_o, 0);
      step_chk("ar_locked", bus.locked_o, 0);
      step_chk("ar_fail", bus.fail_o, 0);
      step_chk("ar_sbits", bus.sbits_o, 0);
      bus.enable = 1'b0;
      #1;
      rst = 1'b0;
      tick();
      step_chk("ar_idle_after", bus.state_o, S_IDLE);
      bus.enable = 1'b1;
      bus.timeout_i = 16'd100;
      bus.sot_is_aligned = 1'b1;
      tick();
      step_chk("ar_resume_state", bus.state_o, S_REALIGN);
      step_chk("ar_resume_realign", bus.realign_req, 1);
      wait_state(S_LOCKED, 20, "ar_relock");
      step_chk("ar_relock_locked_o", bus.locked_o, 1);

      if (sb.size() != 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sot_alignment_monitor.md
SOT_ALIGNMENT_MONITOR -- requirements
Module: sot_alignment_monitor

Interface
REQ-001 Parameter RESET_CYCLES, default 4: realign_req pulse length in clock cycles; legal range 1..15.
REQ-002 Parameter MAX_RETRIES, default 4: consecutive failed lock attempts before FAILED; legal range 1..15.
REQ-003 Parameter MXSBITS, default 64: S-bit bus width.
REQ-004 clock  input  1  single clock; the block has one clock; all logic is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  run monitor; 0 forces IDLE.
REQ-007 sot_is_aligned  input  1  lock status from the frame aligner.
REQ-008 sot_unstable  input  1  sticky loss-of-lock flag from the frame aligner.
REQ-009 timeout_i  input  16  lock timeout in cycles; 0 means one cycle.
REQ-010 cnt_reset  input  1  clears unstable_cnt_o.
REQ-011 sbits_i  input  MXSBITS  aligned S-bits from the frame aligner.
REQ-012 sbits_o  output  MXSBITS  S-bits gated by lock status.
REQ-013 realign_req  output  1  drives the frame aligner reset_i.
REQ-014 state_o  output  3  FSM state encoding.
REQ-015 locked_o  output  1  high only in LOCKED.
REQ-016 fail_o  output  1  high only in FAILED.
REQ-017 retry_cnt_o  output  4  failed attempts since the last lock.
REQ-018 unstable_cnt_o  output  8  saturating count of lock losses.

Function
REQ-019 FSM states and encodings: IDLE=0, REALIGN=1, WAIT_LOCK=2, LOCKED=3, FAILED=4; state_o presents the current state; codes 5-7 are unreachable and SHALL recover to IDLE on the next edge.
REQ-020 IDLE: if enable=1, go to REALIGN, load the pulse counter with RESET_CYCLES, and clear retry_cnt_o.
REQ-021 REALIGN: realign_req=1 for exactly RESET_CYCLES consecutive cycles, then go to WAIT_LOCK with the timeout timer cleared.
REQ-022 realign_req SHALL be a registered output, high only while state=REALIGN.
REQ-023 WAIT_LOCK: the timer increments each cycle (16-bit).
REQ-024 WAIT_LOCK, lock: if sot_is_aligned=1 and sot_unstable=0, go to LOCKED and clear retry_cnt_o.
REQ-025 WAIT_LOCK, timeout: otherwise, when timer==timeout_i, increment retry_cnt_o; go to FAILED if the new value equals MAX_RETRIES, else go to REALIGN.
REQ-026 WAIT_LOCK priority: lock and timeout in the same cycle resolves as lock.
REQ-027 LOCKED, lock loss: if sot_unstable=1 or sot_is_aligned=0, increment unstable_cnt_o (saturate at 255) and go to REALIGN.
REQ-028 FAILED: hold until enable=0.
REQ-029 enable=0 in any state: go to IDLE on the next edge, with realign_req=0 from that edge; this has priority over all other transitions.
REQ-030 unstable_cnt_o clear: cnt_reset=1 clears unstable_cnt_o in any state; a clear in the same cycle as an increment leaves 0.
REQ-031 unstable_cnt_o is not affected by enable.
REQ-032 sbits_o latency: one registered cycle; sbits_o = sbits_i of the previous cycle when the state in that previous cycle was LOCKED, else all zeros.
REQ-033 locked_o and fail_o are registered decodes of the next state, so they change on the same edge as state_o.

Reset
REQ-034 On reset assertion, immediately and asynchronously: state_o=IDLE, realign_req=0, locked_o=0, fail_o=0, retry_cnt_o=0, unstable_cnt_o=0, sbits_o=0, timer and pulse counter 0.
REQ-035 Reset assertion mid-REALIGN SHALL drop realign_req without completing the pulse.
REQ-036 After reset deassertion, the first transition occurs on the first rising edge with enable=1.

Verification
REQ-037 Basic lock: enable=1, sot_is_aligned rises 10 cycles after realign_req falls, timeout_i=100 -> realign_req high exactly 4 cycles, state LOCKED, locked_o=1, retry_cnt_o=0, sbits_o=sbits_i delayed 1 cycle.
REQ-038 Retry to failure: timeout_i=20, sot_is_aligned held 0 -> 4 realign_req pulses, retry_cnt_o=4, state FAILED, fail_o=1, sbits_o=0; then enable=0 -> IDLE next cycle.
REQ-039 Lock loss: in LOCKED, pulse sot_unstable for 1 cycle -> unstable_cnt_o 0->1, state REALIGN, sbits_o zero from the cycle after the loss, relock returns to LOCKED.
REQ-040 Saturation and clear: 300 lock losses -> unstable_cnt_o=255; cnt_reset coincident with a loss -> 0.
REQ-041 Async reset: assert reset mid-REALIGN between edges -> realign_req and all outputs 0 before the next edge; resume on enable.
REQ-042 Lock/timeout tie: sot_is_aligned rises in the cycle timer==timeout_i -> LOCKED, retry_cnt_o unchanged at 0.
